nes_joypad_responder: RTL and testbench
=======================================

NES_JOYPAD_RESPONDER -- requirements
Module: nes_joypad_responder

Interface
REQ-001 SHALL have parameter DEBOUNCE_W, default 16, width of the per-button debounce counter; a change is accepted after 2^DEBOUNCE_W stable cycles.
REQ-002 SHALL have parameter TURBO_W, default 20, width of the turbo divider; turbo phase = divider MSB.
REQ-003 clock  in  1  system clock; all state on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 btn_raw  in  8  raw board buttons, active-high, asynchronous; bit order A,B,Select,Start,Up,Down,Left,Right (bit0=A).
REQ-006 turbo_a  in  1  asynchronous; holds auto-fire on A.
REQ-007 turbo_b  in  1  asynchronous; holds auto-fire on B.
REQ-008 joy_strobe  in  1  host latch line, asynchronous.
REQ-009 joy_clock  in  1  host shift clock, asynchronous.
REQ-010 joy_data  out  1  serial data; pressed = low.
REQ-011 buttons_q  out  8  debounced, turbo-applied button state, active-high.
REQ-012 bit_count  out  4  shifts since last load, saturating at 8.

Function
REQ-013 SHALL pass btn_raw, turbo_a, turbo_b, joy_strobe and joy_clock each through a 2-flop synchroniser.
REQ-014 SHALL keep one debounce counter per button: cleared when the synchronised input equals the accepted state; otherwise incremented; on reaching all-ones the accepted state SHALL toggle and the counter SHALL clear.
REQ-015 buttons_q SHALL equal the accepted states, with turbo modification per REQ-027.
REQ-016 SHALL hold an 8-bit shift register sr; joy_data SHALL equal ~sr[0], registered.
REQ-017 While synchronised strobe is high, sr SHALL load buttons_q every cycle and bit_count SHALL be 0.
REQ-018 On a synchronised joy_clock rising edge with strobe low, sr SHALL shift right with 1 into bit7, and bit_count SHALL increment, saturating at 8.
REQ-019 After 8 or more shifts, joy_data SHALL stay low until the next load.
REQ-020 If a strobe-high cycle and a clock rising edge coincide, load SHALL win and the edge SHALL be discarded.
REQ-021 A strobe falling edge SHALL cause no action; sr SHALL keep the last loaded value.
REQ-022 Latency: a change on joy_strobe or joy_clock pins SHALL affect joy_data no later than 4 clock cycles after the pin edge.
REQ-023 joy_clock falling edges SHALL have no effect; joy_data SHALL be stable from the rising-edge update until the next rising edge or load.

Reset
REQ-024 On reset_n low, asynchronously: synchronisers, accepted states, debounce counters, turbo divider, sr and bit_count SHALL be 0; buttons_q = 0; joy_data = 1.
REQ-025 Reset mid-read SHALL abandon the read; after release the first load SHALL restart from A.
REQ-026 No internal synchronisation of reset release is required; upstream supplies a synchronised deassertion.

Configuration
REQ-027 With JOYPAD_TURBO_EN defined, a free-running TURBO_W-bit divider SHALL exist; buttons_q[0] = accepted A OR (synchronised turbo_a AND phase), and buttons_q[1] likewise with B and turbo_b.
REQ-028 Without JOYPAD_TURBO_EN, the divider SHALL not be built; turbo_a/turbo_b SHALL be ignored and buttons_q SHALL equal the accepted states.

Verification (DEBOUNCE_W=3, TURBO_W=4)
REQ-029 Reset: reset_n=0 with random inputs -> joy_data=1, buttons_q=0x00, bit_count=0.
REQ-030 Debounce: btn_raw[0] glitches high for 5 cycles -> buttons_q stays 0x00; btn_raw=0x09 held -> buttons_q=0x09 within 12 cycles.
REQ-031 Read: buttons_q=0x09, strobe pulse, 10 joy_clock pulses -> data at each falling edge 0,1,1,0,1,1,1,1,0,0; bit_count saturates at 8.
REQ-032 Collision: joy_clock rising in the same synchronised cycle as strobe high -> no shift; first bit after strobe is A.
REQ-033 Reset mid-read after 3 shifts -> joy_data=1 immediately, bit_count=0; the next read returns a full 8 bits.
REQ-034 Turbo (JOYPAD_TURBO_EN): turbo_a held, btn_raw=0 -> buttons_q[0] toggles every 8 cycles; macro undefined -> buttons_q[0]=0.

Source files
------------

// File: rtl/nes_joypad_responder.sv
// nes_joypad_responder
//   Emulates an NES controller toward a host: debounces eight board buttons
//   and serves them on the joypad serial protocol (latch on strobe, shift on
//   each rising edge of the host shift clock, pressed reads as low).
//
//   Parameters:
//     DEBOUNCE_W - per-button debounce counter width; a change is accepted
//                  after 2^DEBOUNCE_W consecutive cycles of disagreement
//     TURBO_W    - turbo divider width; turbo phase is the divider MSB
//
//   Ports:
//     clock, reset_n      system clock, asynchronous active-low reset
//     btn_raw[7:0]        raw buttons, active-high (A,B,Select,Start,Up,Down,Left,Right; bit0=A)
//     turbo_a, turbo_b    auto-fire holds for A and B
//     joy_strobe          host latch line
//     joy_clock           host shift clock
//     joy_data            serial data to host, registered, pressed = low
//     buttons_q[7:0]      debounced, turbo-applied button state, registered
//     bit_count[3:0]      shifts since last load, saturating at 8
//
//   Build option:
//     JOYPAD_TURBO_EN     builds the turbo divider and auto-fire on A/B;
//                         when undefined turbo_a/turbo_b are ignored.

module nes_joypad_responder #(
   parameter int unsigned DEBOUNCE_W = 16,
   parameter int unsigned TURBO_W    = 20
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] btn_raw,
   input  logic       turbo_a,
   input  logic       turbo_b,
   input  logic       joy_strobe,
   input  logic       joy_clock,
   output logic       joy_data,
   output logic [7:0] buttons_q,
   output logic [3:0] bit_count
);

   localparam int unsigned NUM_BTN   = 8;
   localparam logic [3:0]  COUNT_SAT = 4'd8;

   logic [NUM_BTN-1:0] btn_meta;
   logic [NUM_BTN-1:0] btn_sync;
   logic               strobe_meta;
   logic               strobe_sync;
   logic               jclk_meta;
   logic               jclk_sync;
   logic               jclk_prev;

   // Two-flop synchronisers for the asynchronous host and button pins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         btn_meta    <= '0;
         btn_sync    <= '0;
         strobe_meta <= 1'b0;
         strobe_sync <= 1'b0;
         jclk_meta   <= 1'b0;
         jclk_sync   <= 1'b0;
         jclk_prev   <= 1'b0;
      end else begin
         btn_meta    <= btn_raw;
         btn_sync    <= btn_meta;
         strobe_meta <= joy_strobe;
         strobe_sync <= strobe_meta;
         jclk_meta   <= joy_clock;
         jclk_sync   <= jclk_meta;
         jclk_prev   <= jclk_sync;
      end
   end

   logic [DEBOUNCE_W-1:0] db_cnt [NUM_BTN];
   logic [NUM_BTN-1:0]    accepted;

   // Per-button debounce: count cycles of disagreement, flip once saturated.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         accepted <= '0;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (btn_sync[i] == accepted[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == '1) begin
               accepted[i] <= ~accepted[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DEBOUNCE_W'(1);
            end
         end
      end
   end

`ifdef JOYPAD_TURBO_EN
   logic               ta_meta;
   logic               ta_sync;
   logic               tb_meta;
   logic               tb_sync;
   logic [TURBO_W-1:0] turbo_div;
   logic               turbo_phase;

   // Turbo hold synchronisers and free-running auto-fire divider.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ta_meta   <= 1'b0;
         ta_sync   <= 1'b0;
         tb_meta   <= 1'b0;
         tb_sync   <= 1'b0;
         turbo_div <= '0;
      end else begin
         ta_meta   <= turbo_a;
         ta_sync   <= ta_meta;
         tb_meta   <= turbo_b;
         tb_sync   <= tb_meta;
         turbo_div <= turbo_div + TURBO_W'(1);
      end
   end

   assign turbo_phase = turbo_div[TURBO_W-1];
`else
   // Turbo pins are intentionally left unconnected in this build.
   logic unused_turbo;
   assign unused_turbo = turbo_a ^ turbo_b;
`endif

   logic [NUM_BTN-1:0] buttons_next;

   // Accepted state with optional auto-fire ORed onto A and B.
   always_comb begin
      buttons_next = accepted;
`ifdef JOYPAD_TURBO_EN
      buttons_next[0] = accepted[0] | (ta_sync & turbo_phase);
      buttons_next[1] = accepted[1] | (tb_sync & turbo_phase);
`endif
   end

   logic [NUM_BTN-1:0] sr;
   logic               jclk_rise;

   assign jclk_rise = jclk_sync & ~jclk_prev;

   // Host-facing shift register: strobe loads (and wins over a coincident
   // clock edge), rising clock shifts in ones so a finished read reads low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buttons_q <= '0;
         sr        <= '0;
         bit_count <= '0;
         joy_data  <= 1'b1;
      end else begin
         buttons_q <= buttons_next;
         joy_data  <= ~sr[0];
         if (strobe_sync) begin
            sr        <= buttons_q;
            bit_count <= '0;
         end else if (jclk_rise) begin
            sr <= {1'b1, sr[NUM_BTN-1:1]};
            if (bit_count != COUNT_SAT) begin
               bit_count <= bit_count + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Testbench for nes_joypad_responder (DEBOUNCE_W=3, TURBO_W=4).
// A transaction-level model (latched byte + shift count) is compared against
// the DUT on every cycle where the pins have been quiet long enough for the
// synchronisers to settle; directed reads are also checked against literal
// bit sequences.

module tb_nes_joypad_responder;

   localparam int unsigned DW     = 3;
   localparam int unsigned TW     = 4;
   localparam int          SETTLE = (1 << DW) + 5;
   localparam int          JQUIET = 5;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] btn_raw;
   logic       turbo_a;
   logic       turbo_b;
   logic       joy_strobe;
   logic       joy_clock;
   logic       joy_data;
   logic [7:0] buttons_q;
   logic [3:0] bit_count;

   nes_joypad_responder #(
      .DEBOUNCE_W (DW),
      .TURBO_W    (TW)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .btn_raw    (btn_raw),
      .turbo_a    (turbo_a),
      .turbo_b    (turbo_b),
      .joy_strobe (joy_strobe),
      .joy_clock  (joy_clock),
      .joy_data   (joy_data),
      .buttons_q  (buttons_q),
      .bit_count  (bit_count)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   bit         done   = 1'b0;

   // Model: byte captured at the last load and number of accepted shifts.
   logic [7:0] m_latched;
   int         m_shifts;

   logic       exp09 [10];
   logic       exp82 [9];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_data();
      if (m_shifts >= 8) return 1'b0;
      return ~m_latched[m_shifts];
   endfunction

   function automatic logic [3:0] exp_count();
      if (m_shifts >= 8) return 4'd8;
      return 4'(m_shifts);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic strobe_pulse();
      joy_strobe = 1'b1;
      m_latched  = btn_raw;
      m_shifts   = 0;
      cyc(3);
      joy_strobe = 1'b0;
      cyc(6);
   endtask

   // One host clock pulse; d is the data seen just before the falling edge.
   task automatic clk_pulse(output logic d);
      joy_clock = 1'b1;
      if (!joy_strobe) m_shifts++;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      d = joy_data;
      cyc(1);
      joy_clock = 1'b0;
      cyc(6);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b1;
      btn_raw    = 8'h00;
      turbo_a    = 1'b0;
      turbo_b    = 1'b0;
      joy_strobe = 1'b0;
      joy_clock  = 1'b0;
      m_latched  = 8'h00;
      m_shifts   = 0;
      exp09      = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp82      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      #1 reset_n = 1'b0;

      fork
         begin : compare
            logic [9:0] prev_b;
            logic [1:0] prev_j;
            int         qb;
            int         qj;
            qb     = 0;
            qj     = 0;
            prev_b = '0;
            prev_j = '0;
            while (!done) begin
               @(negedge clock);
               if (!reset_n) begin
                  chk("rst_joy_data", 8'(joy_data), 8'd1);
                  chk("rst_buttons_q", buttons_q, 8'h00);
                  chk("rst_bit_count", 8'(bit_count), 8'd0);
                  qb = 0;
                  qj = 0;
               end else begin
                  if ({turbo_b, turbo_a, btn_raw} !== prev_b) qb = 0;
                  else qb++;
                  if ({joy_strobe, joy_clock} !== prev_j) qj = 0;
                  else qj++;
                  if (qb >= SETTLE) begin
`ifdef JOYPAD_TURBO_EN
                     if (!(turbo_a | turbo_b)) chk("model_buttons_q", buttons_q, btn_raw);
`else
                     chk("model_buttons_q", buttons_q, btn_raw);
`endif
                  end
                  if (qj >= JQUIET && (!joy_strobe || qb >= SETTLE)) begin
                     chk("model_joy_data", 8'(joy_data), 8'(exp_data()));
                     chk("model_bit_count", 8'(bit_count), 8'(exp_count()));
                  end
               end
               prev_b = {turbo_b, turbo_a, btn_raw};
               prev_j = {joy_strobe, joy_clock};
            end
         end

         begin : stim
            logic d;
            int   last;
            int   ntr;
            logic pv;
            logic v;

            // Reset held with random pin activity.
            for (int i = 0; i < 6; i++) begin
               btn_raw    = 8'($urandom);
               turbo_a    = 1'($urandom);
               turbo_b    = 1'($urandom);
               joy_strobe = 1'($urandom);
               joy_clock  = 1'($urandom);
               @(negedge clock);
               chk("reset_joy_data", 8'(joy_data), 8'd1);
               chk("reset_buttons_q", buttons_q, 8'h00);
               chk("reset_bit_count", 8'(bit_count), 8'd0);
               cyc(1);
            end
            btn_raw    = 8'h00;
            turbo_a    = 1'b0;
            turbo_b    = 1'b0;
            joy_strobe = 1'b0;
            joy_clock  = 1'b0;
            cyc(2);
            reset_n = 1'b1;
            cyc(4);

            // Short glitch on A must be rejected.
            btn_raw = 8'h01;
            cyc(5);
            btn_raw = 8'h00;
            for (int i = 0; i < 20; i++) begin
               @(negedge clock);
               chk("glitch_buttons_q", buttons_q, 8'h00);
            end
            cyc(1);

            // Held A+Start accepted within 12 cycles.
            btn_raw = 8'h09;
            repeat (12) @(posedge clock);
            @(negedge clock);
            chk("debounce_accept", buttons_q, 8'h09);
            cyc(4);

            // Full read of 0x09 with two extra clocks.
            strobe_pulse();
            for (int i = 0; i < 10; i++) begin
               clk_pulse(d);
               chk($sformatf("read09_bit%0d", i), 8'(d), 8'(exp09[i]));
            end
            chk("read09_count_sat", 8'(bit_count), 8'd8);

            // Clock edge coinciding with strobe is discarded.
            joy_strobe = 1'b1;
            joy_clock  = 1'b1;
            m_latched  = btn_raw;
            m_shifts   = 0;
            cyc(4);
            joy_strobe = 1'b0;
            cyc(4);
            joy_clock = 1'b0;
            cyc(6);
            @(negedge clock);
            chk("collide_joy_data", 8'(joy_data), 8'd0);
            chk("collide_bit_count", 8'(bit_count), 8'd0);
            cyc(1);
            clk_pulse(d);
            chk("collide_first_bit_a", 8'(d), 8'd0);
            @(negedge clock);
            chk("collide_after_shift_data", 8'(joy_data), 8'd1);
            chk("collide_after_shift_count", 8'(bit_count), 8'd1);
            cyc(1);

            // Reset in the middle of a read, then a complete read.
            strobe_pulse();
            for (int i = 0; i < 3; i++) clk_pulse(d);
            reset_n   = 1'b0;
            m_latched = 8'h00;
            m_shifts  = 0;
            #1;
            chk("midrst_joy_data", 8'(joy_data), 8'd1);
            chk("midrst_bit_count", 8'(bit_count), 8'd0);
            chk("midrst_buttons_q", buttons_q, 8'h00);
            cyc(2);
            reset_n = 1'b1;
            cyc(SETTLE + 2);
            strobe_pulse();
            for (int i = 0; i < 8; i++) begin
               clk_pulse(d);
               chk($sformatf("postrst_bit%0d", i), 8'(d), 8'(exp09[i]));
            end
            chk("postrst_count", 8'(bit_count), 8'd8);

            // B+Right pattern.
            btn_raw = 8'h82;
            cyc(SETTLE + 2);
            strobe_pulse();
            for (int i = 0; i < 9; i++) begin
               clk_pulse(d);
               chk($sformatf("read82_bit%0d", i), 8'(d), 8'(exp82[i]));
            end

            // Turbo on A with no buttons pressed.
            btn_raw = 8'h00;
            cyc(SETTLE + 2);
            turbo_a = 1'b1;
            cyc(4);
`ifdef JOYPAD_TURBO_EN
            last = -1;
            ntr  = 0;
            pv   = buttons_q[0];
            for (int i = 0; i < 64; i++) begin
               @(negedge clock);
               v = buttons_q[0];
               if (v !== pv) begin
                  if (last >= 0) chk("turbo_period", 8'(i - last), 8'd8);
                  last = i;
                  ntr++;
               end
               pv = v;
            end
            chk("turbo_toggled", 8'(ntr >= 4), 8'd1);
`else
            last = 0;
            ntr  = 0;
            pv   = 1'b0;
            v    = 1'b0;
            for (int i = 0; i < 48; i++) begin
               @(negedge clock);
               chk("turbo_ignored", buttons_q, 8'h00);
            end
`endif
            cyc(1);
            turbo_a = 1'b0;
            cyc(SETTLE + 2);
            done = 1'b1;
         end
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
